socket_rxd: RTL and testbench

//  Socket-0 UDP receive sequencer for the W5500; mirror of the transmit sequencer on the same SPI command engine.

---
 rtl/socket_rxd_pkg.sv | 55 +++++
 rtl/w5500_be_shift.sv | 44 ++++
 rtl/socket_rxd.sv | 260 ++++++++++++++++++++++++++
 tb/tb_socket_rxd.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/socket_rxd_pkg.sv
// Shared W5500 socket-0 constants: register addresses, control bytes,
// command/interrupt bit values and the sequencer state encoding used by
// both the receive and transmit sequencers.
package socket_rxd_pkg;

   // Largest UDP payload delivered to the user side
   localparam logic [15:0] DEF_MAX_LEN = 16'd1472;

   // SPI control bytes (block select + read/write + variable-length mode)
   localparam logic [7:0] DEF_CMD_REG_RD = 8'h08;
   localparam logic [7:0] DEF_CMD_REG_WR = 8'h0C;
   localparam logic [7:0] DEF_CMD_RXB_RD = 8'h18;

   // Socket register addresses
   localparam logic [15:0] SN_CR     = 16'h0001;
   localparam logic [15:0] SN_IR     = 16'h0002;
   localparam logic [15:0] SN_RX_RSR = 16'h0026;
   localparam logic [15:0] SN_RX_RD  = 16'h0028;

   // Command / interrupt values
   localparam logic [7:0] CR_RECV     = 8'h40;
   localparam logic [7:0] IR_RECV     = 8'h04;
   localparam int         IR_RECV_BIT = 2;

   // W5500 UDP receive header: 4 bytes IP, 2 bytes port, 2 bytes length
   localparam int          HDR_BYTES = 8;
   localparam logic [15:0] HDR_LEN   = 16'd8;

   // Top-level task code that enables the receive sequencer
   localparam logic [3:0] TASK_RX = 4'd5;

   typedef enum logic [4:0] {
      S_IDLE       = 5'd0,
      S_RDIR_CMD   = 5'd1,
      S_RD_IR      = 5'd2,
      S_JDIR       = 5'd3,
      S_RDRSR_CMD  = 5'd4,
      S_RD_RSR     = 5'd5,
      S_JDRSR      = 5'd6,
      S_RDRXRD_CMD = 5'd7,
      S_RD_RXRD    = 5'd8,
      S_RDHDR_CMD  = 5'd9,
      S_RD_HDR     = 5'd10,
      S_RDBUF_CMD  = 5'd11,
      S_RD_BUF     = 5'd12,
      S_WRRXRD_CMD = 5'd13,
      S_WR_RXRD    = 5'd14,
      S_WRCR_CMD   = 5'd15,
      S_WR_CR      = 5'd16,
      S_WRIR_CMD   = 5'd17,
      S_WR_IR      = 5'd18,
      S_END        = 5'd19
   } sock_state_t;

endpackage

// File: rtl/w5500_be_shift.sv
// Big-endian byte assembler for SPI engine read data. Each enabled byte is
// shifted in at the low end, so after N bytes the first byte received sits
// in the most significant position. The byte counter counts enabled bytes
// and is cleared by clr. word_nxt shows the value including the byte being
// accepted this cycle, so a caller can latch a complete field in the same
// cycle the last byte and the end-of-transaction strobe coincide.
module w5500_be_shift #(
   parameter int NBYTES = 8,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [7:0]            din,
   output logic [8*NBYTES-1:0]   word_nxt,
   output logic [CNT_W-1:0]      cnt
);

   logic [8*NBYTES-1:0] word_q;

   // Shift-in view of the word including the byte accepted this cycle
   always_comb begin
      word_nxt = word_q;
      if (en) begin
         word_nxt = {word_q[8*NBYTES-9:0], din};
      end
   end

   // Word and byte-counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q <= '0;
         cnt    <= '0;
      end else if (clr) begin
         word_q <= '0;
         cnt    <= '0;
      end else if (en) begin
         word_q <= word_nxt;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/socket_rxd.sv
// Socket-0 UDP receive sequencer for the W5500. One pass per request:
// poll Sn_IR.RECV, read Sn_RX_RSR and Sn_RX_RD, read the 8-byte UDP header,
// stream the payload (or skip the datagram), advance Sn_RX_RD, issue RECV
// to Sn_CR and clear IR.RECV.
//
// Engine handshake: o_start is a 1-cycle pulse that launches a transaction
// described by o_cmd/o_addr/o_length (held stable until the next start).
// For reads the engine presents each byte with den=1 for one cycle; for
// writes it pulses rdreq to request the next byte, and o_dat carries that
// byte from the following cycle. wrend pulses once when the transaction is
// complete; the sequencer waits for it in every transfer state.
module socket_rxd
   import socket_rxd_pkg::*;
#(
   parameter logic [15:0] MAX_LEN    = DEF_MAX_LEN,
   parameter logic [7:0]  CMD_REG_RD = DEF_CMD_REG_RD,
   parameter logic [7:0]  CMD_REG_WR = DEF_CMD_REG_WR,
   parameter logic [7:0]  CMD_RXB_RD = DEF_CMD_RXB_RD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  task_state,
   input  logic        dat_rx_req,
   input  logic        rdreq,
   input  logic        den,
   input  logic [7:0]  din,
   input  logic        wrend,
   output logic        o_start,
   output logic [7:0]  o_cmd,
   output logic [15:0] o_addr,
   output logic [15:0] o_length,
   output logic [7:0]  o_dat,
   output logic        rxdat_vld,
   output logic [7:0]  rxdat,
   output logic [15:0] rxdat_len,
   output logic [31:0] rx_sip,
   output logic [15:0] rx_sport,
   output logic        o_rx_end
);

   sock_state_t state, state_nxt;

   // Values captured from the register / header reads
   logic        ir_recv;
   logic [15:0] rsr;
   logic [15:0] rx_ptr;
   logic [15:0] hdr_len;
   logic        deliver;

   // Transfer-state decode and byte-accept qualification
   logic        is_rd, is_wr;
   logic [15:0] rd_limit, wr_limit;
   logic        sh_en, sh_clr;
   logic [63:0] word_nxt;
   logic [15:0] cnt;

   // Header fields as they stand including the current byte
   logic [31:0] h_sip;
   logic [15:0] h_sport;
   logic [15:0] h_len;
   logic        hdr_ok;

   // Next transaction descriptor
   logic        cmd_vld;
   logic [7:0]  cmd_nxt;
   logic [15:0] addr_nxt, len_nxt;

   logic [15:0] new_ptr;

   assign h_sip   = word_nxt[63:32];
   assign h_sport = word_nxt[31:16];
   assign h_len   = word_nxt[15:0];

   // A datagram is delivered only if non-empty, within MAX_LEN and wholly
   // present in the RX buffer; the sum is widened so it cannot wrap.
   assign hdr_ok = (h_len != 16'd0) && (h_len <= MAX_LEN) &&
                   (({1'b0, h_len} + {1'b0, HDR_LEN}) <= {1'b0, rsr});

   // Read pointer after this datagram: past the payload, or past everything
   // reported in RSR when the datagram is skipped. 16-bit wrap is intended.
   assign new_ptr = deliver ? (rx_ptr + HDR_LEN + hdr_len) : (rx_ptr + rsr);

   assign o_rx_end = (state == S_END);

   // Classify transfer states and the number of bytes each accepts
   always_comb begin
      is_rd    = 1'b0;
      is_wr    = 1'b0;
      rd_limit = 16'd0;
      wr_limit = 16'd0;
      case (state)
         S_RD_IR:   begin is_rd = 1'b1; rd_limit = 16'd1;   end
         S_RD_RSR:  begin is_rd = 1'b1; rd_limit = 16'd2;   end
         S_RD_RXRD: begin is_rd = 1'b1; rd_limit = 16'd2;   end
         S_RD_HDR:  begin is_rd = 1'b1; rd_limit = HDR_LEN; end
         S_RD_BUF:  begin is_rd = 1'b1; rd_limit = hdr_len; end
         S_WR_RXRD: begin is_wr = 1'b1; wr_limit = 16'd2;   end
         S_WR_CR:   begin is_wr = 1'b1; wr_limit = 16'd1;   end
         S_WR_IR:   begin is_wr = 1'b1; wr_limit = 16'd1;   end
         default:   ;
      endcase
      sh_en  = (is_rd && den   && (cnt < rd_limit)) ||
               (is_wr && rdreq && (cnt < wr_limit));
      sh_clr = !(is_rd || is_wr);
   end

   w5500_be_shift #(
      .NBYTES (HDR_BYTES),
      .CNT_W  (16)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sh_clr),
      .en       (sh_en),
      .din      (din),
      .word_nxt (word_nxt),
      .cnt      (cnt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the transaction each command state launches
   always_comb begin
      state_nxt = state;
      cmd_vld   = 1'b0;
      cmd_nxt   = 8'h00;
      addr_nxt  = 16'h0000;
      len_nxt   = 16'h0000;
      case (state)
         S_IDLE:
            state_nxt = (dat_rx_req && (task_state == TASK_RX)) ? S_RDIR_CMD : S_END;
         S_RDIR_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_REG_RD; addr_nxt = SN_IR; len_nxt = 16'd1;
            state_nxt = S_RD_IR;
         end
         S_RD_IR:   if (wrend) state_nxt = S_JDIR;
         S_JDIR:    state_nxt = ir_recv ? S_RDRSR_CMD : S_END;
         S_RDRSR_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_REG_RD; addr_nxt = SN_RX_RSR; len_nxt = 16'd2;
            state_nxt = S_RD_RSR;
         end
         S_RD_RSR:  if (wrend) state_nxt = S_JDRSR;
         S_JDRSR:   state_nxt = (rsr == 16'd0) ? S_END : S_RDRXRD_CMD;
         S_RDRXRD_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_REG_RD; addr_nxt = SN_RX_RD; len_nxt = 16'd2;
            state_nxt = S_RD_RXRD;
         end
         S_RD_RXRD: if (wrend) state_nxt = S_RDHDR_CMD;
         S_RDHDR_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_RXB_RD; addr_nxt = rx_ptr; len_nxt = HDR_LEN;
            state_nxt = S_RD_HDR;
         end
         S_RD_HDR:  if (wrend) state_nxt = hdr_ok ? S_RDBUF_CMD : S_WRRXRD_CMD;
         S_RDBUF_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_RXB_RD; addr_nxt = rx_ptr + HDR_LEN; len_nxt = hdr_len;
            state_nxt = S_RD_BUF;
         end
         S_RD_BUF:  if (wrend) state_nxt = S_WRRXRD_CMD;
         S_WRRXRD_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_REG_WR; addr_nxt = SN_RX_RD; len_nxt = 16'd2;
            state_nxt = S_WR_RXRD;
         end
         S_WR_RXRD: if (wrend) state_nxt = S_WRCR_CMD;
         S_WRCR_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_REG_WR; addr_nxt = SN_CR; len_nxt = 16'd1;
            state_nxt = S_WR_CR;
         end
         S_WR_CR:   if (wrend) state_nxt = S_WRIR_CMD;
         S_WRIR_CMD: begin
            cmd_vld = 1'b1; cmd_nxt = CMD_REG_WR; addr_nxt = SN_IR; len_nxt = 16'd1;
            state_nxt = S_WR_IR;
         end
         S_WR_IR:   if (wrend) state_nxt = S_END;
         S_END:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Engine command outputs: start pulse plus a held descriptor
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_start  <= 1'b0;
         o_cmd    <= 8'h00;
         o_addr   <= 16'h0000;
         o_length <= 16'h0000;
      end else begin
         o_start <= cmd_vld;
         if (cmd_vld) begin
            o_cmd    <= cmd_nxt;
            o_addr   <= addr_nxt;
            o_length <= len_nxt;
         end
      end
   end

   // Capture register reads and the header at the end of each read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_recv   <= 1'b0;
         rsr       <= 16'h0000;
         rx_ptr    <= 16'h0000;
         hdr_len   <= 16'h0000;
         deliver   <= 1'b0;
         rx_sip    <= 32'h0;
         rx_sport  <= 16'h0000;
         rxdat_len <= 16'h0000;
      end else if (wrend) begin
         case (state)
            S_RD_IR:   ir_recv <= word_nxt[IR_RECV_BIT];
            S_RD_RSR:  rsr     <= word_nxt[15:0];
            S_RD_RXRD: rx_ptr  <= word_nxt[15:0];
            S_RD_HDR: begin
               hdr_len <= h_len;
               deliver <= hdr_ok;
               if (hdr_ok) begin
                  rx_sip    <= h_sip;
                  rx_sport  <= h_sport;
                  rxdat_len <= h_len;
               end
            end
            default: ;
         endcase
      end
   end

   // Payload stream: one registered pulse per accepted buffer byte
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxdat_vld <= 1'b0;
         rxdat     <= 8'h00;
      end else begin
         rxdat_vld <= sh_en && (state == S_RD_BUF);
         if (sh_en && (state == S_RD_BUF)) begin
            rxdat <= din;
         end
      end
   end

   // Write data: next byte of the current write, presented after rdreq
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_dat <= 8'h00;
      end else if (sh_en && is_wr) begin
         case (state)
            S_WR_RXRD: o_dat <= (cnt == 16'd0) ? new_ptr[15:8] : new_ptr[7:0];
            S_WR_CR:   o_dat <= CR_RECV;
            S_WR_IR:   o_dat <= IR_RECV;
            default:   o_dat <= 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_socket_rxd.sv
// Directed bench for socket_rxd: a small W5500 engine/memory model answers
// the sequencer's transactions, and each test task compares the observed
// transaction log, written bytes and payload stream with hand-worked values.
module tb_socket_rxd;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  task_state;
   logic        dat_rx_req;
   logic        rdreq, den, wrend;
   logic [7:0]  din;
   logic        o_start;
   logic [7:0]  o_cmd;
   logic [15:0] o_addr, o_length;
   logic [7:0]  o_dat;
   logic        rxdat_vld;
   logic [7:0]  rxdat;
   logic [15:0] rxdat_len;
   logic [31:0] rx_sip;
   logic [15:0] rx_sport;
   logic        o_rx_end;

   always #5 clk = ~clk;

   socket_rxd dut (
      .clk(clk), .rst_n(rst_n), .task_state(task_state), .dat_rx_req(dat_rx_req),
      .rdreq(rdreq), .den(den), .din(din), .wrend(wrend),
      .o_start(o_start), .o_cmd(o_cmd), .o_addr(o_addr), .o_length(o_length),
      .o_dat(o_dat), .rxdat_vld(rxdat_vld), .rxdat(rxdat), .rxdat_len(rxdat_len),
      .rx_sip(rx_sip), .rx_sport(rx_sport), .o_rx_end(o_rx_end)
   );

   // ---------------- model state and scoreboard queues ----------------
   logic [7:0]  sreg  [64];
   logic [7:0]  rxbuf [65536];
   logic [39:0] tr_q[$];
   logic [39:0] exp_q[$];
   logic [7:0]  wr_q[$];
   logic [7:0]  exp_w[$];
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_b[$];
   logic [15:0] rxlen_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [39:0] tr(input logic [7:0] c, input logic [15:0] a,
                                      input logic [15:0] l);
      return {c, a, l};
   endfunction

   // First index where two logs differ, -1 when identical
   function automatic int diff40(input logic [39:0] a[$], input logic [39:0] b[$]);
      int n = (a.size() > b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++)
         if (i >= a.size() || i >= b.size() || a[i] !== b[i]) return i;
      return -1;
   endfunction

   function automatic int diff8(input logic [7:0] a[$], input logic [7:0] b[$]);
      int n = (a.size() > b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++)
         if (i >= a.size() || i >= b.size() || a[i] !== b[i]) return i;
      return -1;
   endfunction

   // ---------------- engine model (driver side) ----------------
   initial begin : engine
      logic [7:0]  e_cmd;
      logic [15:0] e_addr, e_len, a;
      bit          ok;
      den = 1'b0; din = 8'h00; rdreq = 1'b0; wrend = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && o_start === 1'b1) begin
            e_cmd = o_cmd; e_addr = o_addr; e_len = o_length; ok = 1'b1;
            tr_q.push_back({e_cmd, e_addr, e_len});
            for (int i = 0; i < int'(e_len) && ok; i++) begin
               a = e_addr + 16'(i);
               if (e_cmd == 8'h0C) begin
                  rdreq = 1'b1;
                  @(negedge clk);
                  rdreq = 1'b0;
                  wr_q.push_back(o_dat);
                  sreg[a[5:0]] = o_dat;
               end else begin
                  den = 1'b1;
                  din = (e_cmd == 8'h18) ? rxbuf[a] : sreg[a[5:0]];
                  @(negedge clk);
                  den = 1'b0;
               end
               if (rst_n !== 1'b1) ok = 1'b0;
            end
            if (ok) begin
               wrend = 1'b1;
               @(negedge clk);
               wrend = 1'b0;
            end
         end
      end
   end

   // ---------------- payload monitor ----------------
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rxdat_vld === 1'b1) begin
            rx_q.push_back(rxdat);
            rxlen_q.push_back(rxdat_len);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_regs(input logic [7:0] ir, input logic [15:0] rsr, input logic [15:0] rxrd);
      sreg[6'h02] = ir;
      sreg[6'h26] = rsr[15:8];  sreg[6'h27] = rsr[7:0];
      sreg[6'h28] = rxrd[15:8]; sreg[6'h29] = rxrd[7:0];
   endtask

   task automatic put_dgram(input logic [15:0] ptr, input logic [31:0] sip,
                            input logic [15:0] sport, input logic [15:0] len,
                            input logic [7:0] seed);
      logic [63:0] h;
      logic [15:0] a;
      h = {sip, sport, len};
      for (int i = 0; i < 8; i++) begin
         a = ptr + 16'(i);
         rxbuf[a] = h[63-8*i -: 8];
      end
      for (int i = 0; i < int'(len); i++) begin
         a = ptr + 16'd8 + 16'(i);
         rxbuf[a] = seed + 8'(i);
      end
   endtask

   // Expected transaction log for a sequence that reaches the header read
   task automatic exp_seq(input logic [15:0] ptr, input bit dlv,
                          input logic [15:0] buf_addr, input logic [15:0] len);
      exp_q.delete();
      exp_q.push_back(tr(8'h08, 16'h0002, 16'd1));
      exp_q.push_back(tr(8'h08, 16'h0026, 16'd2));
      exp_q.push_back(tr(8'h08, 16'h0028, 16'd2));
      exp_q.push_back(tr(8'h18, ptr, 16'd8));
      if (dlv) exp_q.push_back(tr(8'h18, buf_addr, len));
      exp_q.push_back(tr(8'h0C, 16'h0028, 16'd2));
      exp_q.push_back(tr(8'h0C, 16'h0001, 16'd1));
      exp_q.push_back(tr(8'h0C, 16'h0002, 16'd1));
   endtask

   task automatic exp_writes(input logic [15:0] new_ptr);
      exp_w.delete();
      exp_w.push_back(new_ptr[15:8]);
      exp_w.push_back(new_ptr[7:0]);
      exp_w.push_back(8'h40);
      exp_w.push_back(8'h04);
   endtask

   task automatic exp_payload(input logic [7:0] seed, input int len);
      exp_b.delete();
      for (int i = 0; i < len; i++) exp_b.push_back(seed + 8'(i));
   endtask

   // One request; waits (bounded) for o_rx_end
   task automatic run_req(input logic [3:0] ts, output bit got_end);
      tr_q.delete(); wr_q.delete(); rx_q.delete(); rxlen_q.delete();
      @(negedge clk);
      task_state = ts;
      dat_rx_req = 1'b1;
      got_end = 1'b0;
      for (int c = 0; c < 5000 && !got_end; c++) begin
         @(negedge clk);
         if (o_rx_end === 1'b1) got_end = 1'b1;
      end
      dat_rx_req = 1'b0;
      task_state = 4'd0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0; task_state = 4'd5; dat_rx_req = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({o_start, o_cmd, o_addr, o_length, o_dat} !== 49'h0) begin
         errors++; $display("FAIL reset_cmd_outputs: got %h required 0", {o_start, o_cmd, o_addr, o_length, o_dat});
      end
      checks++;
      if ({rxdat_vld, rxdat, rxdat_len} !== 25'h0) begin
         errors++; $display("FAIL reset_rx_outputs: got %h required 0", {rxdat_vld, rxdat, rxdat_len});
      end
      checks++;
      if ({rx_sip, rx_sport} !== 48'h0) begin
         errors++; $display("FAIL reset_hdr_outputs: got %h required 0", {rx_sip, rx_sport});
      end
      checks++;
      if (o_rx_end !== 1'b0) begin
         errors++; $display("FAIL reset_rx_end: got %b required 0", o_rx_end);
      end
      dat_rx_req = 1'b0; task_state = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_no_recv;
      bit e; int d;
      set_regs(8'h00, 16'h0000, 16'h0000);
      run_req(4'd5, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL norecv_end: got %b required 1", e); end
      exp_q.delete();
      exp_q.push_back(tr(8'h08, 16'h0002, 16'd1));
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0) begin
         errors++; $display("FAIL norecv_trans: n=%0d got %h required n=%0d %h", tr_q.size(), tr_q[d], exp_q.size(), exp_q[d]);
      end
      checks++;
      if (rx_q.size() != 0) begin errors++; $display("FAIL norecv_rxvld: got %0d pulses required 0", rx_q.size()); end
   endtask

   task automatic test_deliver;
      bit e; int d; int bad;
      set_regs(8'h04, 16'h000C, 16'h0100);
      put_dgram(16'h0100, 32'hC0A80005, 16'h1770, 16'd4, 8'hA1);
      run_req(4'd5, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL deliver_end: got %b required 1", e); end
      exp_seq(16'h0100, 1'b1, 16'h0108, 16'd4);
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0) begin
         errors++; $display("FAIL deliver_trans: #%0d n=%0d got %h required n=%0d %h", d, tr_q.size(), tr_q[d], exp_q.size(), exp_q[d]);
      end
      exp_writes(16'h010C);
      d = diff8(wr_q, exp_w);
      checks++;
      if (d >= 0) begin
         errors++; $display("FAIL deliver_writes: #%0d got %h required %h", d, wr_q[d], exp_w[d]);
      end
      exp_payload(8'hA1, 4);
      d = diff8(rx_q, exp_b);
      checks++;
      if (d >= 0) begin
         errors++; $display("FAIL deliver_payload: #%0d n=%0d got %h required n=4 %h", d, rx_q.size(), rx_q[d], exp_b[d]);
      end
      checks++;
      if ({rx_sip, rx_sport, rxdat_len} !== {32'hC0A80005, 16'd6000, 16'd4}) begin
         errors++; $display("FAIL deliver_hdr: got %h %h %h required c0a80005 1770 0004", rx_sip, rx_sport, rxdat_len);
      end
      bad = 0;
      foreach (rxlen_q[i]) if (rxlen_q[i] !== 16'd4) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL deliver_len_during_vld: %0d pulses with wrong rxdat_len required 4", bad); end
      checks++;
      if ({sreg[6'h01], sreg[6'h02]} !== 16'h4004) begin
         errors++; $display("FAIL deliver_cr_ir: got %h required 4004", {sreg[6'h01], sreg[6'h02]});
      end
   endtask

   task automatic test_wrap;
      bit e; int d;
      set_regs(8'h04, 16'd12, 16'hFFFC);
      put_dgram(16'hFFFC, 32'h0A000001, 16'h0050, 16'd4, 8'h11);
      run_req(4'd5, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL wrap_end: got %b required 1", e); end
      exp_seq(16'hFFFC, 1'b1, 16'h0004, 16'd4);
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0) begin
         errors++; $display("FAIL wrap_trans: #%0d got %h required %h", d, tr_q[d], exp_q[d]);
      end
      exp_writes(16'h0008);
      d = diff8(wr_q, exp_w);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL wrap_writes: #%0d got %h required %h", d, wr_q[d], exp_w[d]); end
      exp_payload(8'h11, 4);
      d = diff8(rx_q, exp_b);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL wrap_payload: #%0d got %h required %h", d, rx_q[d], exp_b[d]); end
      checks++;
      if ({rx_sip, rx_sport, rxdat_len} !== {32'h0A000001, 16'h0050, 16'd4}) begin
         errors++; $display("FAIL wrap_hdr: got %h %h %h required 0a000001 0050 0004", rx_sip, rx_sport, rxdat_len);
      end
   endtask

   task automatic test_discard_long;
      bit e; int d;
      set_regs(8'h04, 16'd2008, 16'h0200);
      put_dgram(16'h0200, 32'h01020304, 16'h1234, 16'd2000, 8'h00);
      run_req(4'd5, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL discard_end: got %b required 1", e); end
      exp_seq(16'h0200, 1'b0, 16'h0000, 16'd0);
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL discard_trans: #%0d n=%0d got %h required %h", d, tr_q.size(), tr_q[d], exp_q[d]); end
      exp_writes(16'h09D8);
      d = diff8(wr_q, exp_w);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL discard_writes: #%0d got %h required %h", d, wr_q[d], exp_w[d]); end
      checks++;
      if (rx_q.size() != 0) begin errors++; $display("FAIL discard_rxvld: got %0d pulses required 0", rx_q.size()); end
      checks++;
      if ({rx_sip, rx_sport, rxdat_len} !== {32'h0A000001, 16'h0050, 16'd4}) begin
         errors++; $display("FAIL discard_hold: got %h %h %h required 0a000001 0050 0004", rx_sip, rx_sport, rxdat_len);
      end
   endtask

   task automatic test_discard_short_rsr;
      bit e; int d;
      set_regs(8'h04, 16'd11, 16'h0300);
      put_dgram(16'h0300, 32'h05060708, 16'h4321, 16'd4, 8'h30);
      run_req(4'd5, e);
      exp_seq(16'h0300, 1'b0, 16'h0000, 16'd0);
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0 || e !== 1'b1) begin errors++; $display("FAIL shortrsr_trans: end=%b #%0d got %h required %h", e, d, tr_q[d], exp_q[d]); end
      exp_writes(16'h030B);
      d = diff8(wr_q, exp_w);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL shortrsr_writes: #%0d got %h required %h", d, wr_q[d], exp_w[d]); end
      checks++;
      if (rx_q.size() != 0) begin errors++; $display("FAIL shortrsr_rxvld: got %0d pulses required 0", rx_q.size()); end
   endtask

   task automatic test_rsr_zero;
      bit e; int d;
      set_regs(8'h04, 16'h0000, 16'h0500);
      run_req(4'd5, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL rsr0_end: got %b required 1", e); end
      exp_q.delete();
      exp_q.push_back(tr(8'h08, 16'h0002, 16'd1));
      exp_q.push_back(tr(8'h08, 16'h0026, 16'd2));
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL rsr0_trans: #%0d n=%0d got %h required n=2 %h", d, tr_q.size(), tr_q[d], exp_q[d]); end
      checks++;
      if (wr_q.size() != 0) begin errors++; $display("FAIL rsr0_writes: got %0d bytes required 0", wr_q.size()); end
   endtask

   task automatic test_not_task;
      bit e;
      set_regs(8'h04, 16'h000C, 16'h0100);
      run_req(4'd3, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL nottask_end: got %b required 1", e); end
      checks++;
      if (tr_q.size() != 0) begin errors++; $display("FAIL nottask_trans: got %0d transactions required 0", tr_q.size()); end
      checks++;
      if (rx_q.size() != 0) begin errors++; $display("FAIL nottask_rxvld: got %0d pulses required 0", rx_q.size()); end
   endtask

   task automatic test_max_len;
      bit e; int d;
      set_regs(8'h04, 16'd1480, 16'h1000);
      put_dgram(16'h1000, 32'h11223344, 16'h2222, 16'd1472, 8'h00);
      run_req(4'd5, e);
      exp_seq(16'h1000, 1'b1, 16'h1008, 16'd1472);
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0 || e !== 1'b1) begin errors++; $display("FAIL maxlen_trans: end=%b #%0d got %h required %h", e, d, tr_q[d], exp_q[d]); end
      exp_payload(8'h00, 1472);
      d = diff8(rx_q, exp_b);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL maxlen_payload: #%0d n=%0d got %h required n=1472 %h", d, rx_q.size(), rx_q[d], exp_b[d]); end
      exp_writes(16'h15C8);
      d = diff8(wr_q, exp_w);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL maxlen_writes: #%0d got %h required %h", d, wr_q[d], exp_w[d]); end
      checks++;
      if (rxdat_len !== 16'd1472) begin errors++; $display("FAIL maxlen_len: got %0d required 1472", rxdat_len); end
   endtask

   task automatic test_reset_mid;
      bit e; bit seen; int d;
      set_regs(8'h04, 16'd16, 16'h0400);
      put_dgram(16'h0400, 32'hAC100001, 16'h1F90, 16'd8, 8'h50);
      rx_q.delete();
      @(negedge clk);
      task_state = 4'd5; dat_rx_req = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         @(negedge clk);
         if (rxdat_vld === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL resetmid_reach_buf: got no rxdat_vld required one within 500 cycles"); end
      rst_n = 1'b0; dat_rx_req = 1'b0; task_state = 4'd0;
      @(negedge clk);
      checks++;
      if ({o_start, o_cmd, o_addr, o_length, o_dat, rxdat_vld, rxdat, rxdat_len} !== 74'h0) begin
         errors++; $display("FAIL resetmid_outputs: got %h required 0", {o_start, o_cmd, o_addr, o_length, o_dat, rxdat_vld, rxdat, rxdat_len});
      end
      checks++;
      if ({rx_sip, rx_sport, o_rx_end} !== 49'h0) begin
         errors++; $display("FAIL resetmid_hdr: got %h required 0", {rx_sip, rx_sport, o_rx_end});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      set_regs(8'h04, 16'd16, 16'h0400);
      run_req(4'd5, e);
      exp_seq(16'h0400, 1'b1, 16'h0408, 16'd8);
      d = diff40(tr_q, exp_q);
      checks++;
      if (d >= 0 || e !== 1'b1) begin errors++; $display("FAIL resetmid_restart: end=%b #%0d got %h required %h", e, d, tr_q[d], exp_q[d]); end
      exp_payload(8'h50, 8);
      d = diff8(rx_q, exp_b);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL resetmid_payload: #%0d got %h required %h", d, rx_q[d], exp_b[d]); end
      exp_writes(16'h0410);
      d = diff8(wr_q, exp_w);
      checks++;
      if (d >= 0) begin errors++; $display("FAIL resetmid_writes: #%0d got %h required %h", d, wr_q[d], exp_w[d]); end
      checks++;
      if ({rx_sip, rx_sport, rxdat_len} !== {32'hAC100001, 16'h1F90, 16'd8}) begin
         errors++; $display("FAIL resetmid_hdr_after: got %h %h %h required ac100001 1f90 0008", rx_sip, rx_sport, rxdat_len);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0; task_state = 4'd0; dat_rx_req = 1'b0;
      for (int i = 0; i < 64; i++) sreg[i] = 8'h00;
      test_reset();
      test_no_recv();
      test_deliver();
      test_wrap();
      test_discard_long();
      test_discard_short_rsr();
      test_rsr_zero();
      test_not_task();
      test_max_len();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
